// File: rtl/q_isa_pkg.sv
// Shared ISA definitions for the quantum control processor decode path:
// opcodes, control-word field encodings and the control word layout.
package q_isa_pkg;

   localparam logic [6:0] OP_CMP    = 7'h01;
   localparam logic [6:0] OP_BR     = 7'h02;
   localparam logic [6:0] OP_JUMP   = 7'h03;
   localparam logic [6:0] OP_LD     = 7'h04;
   localparam logic [6:0] OP_ST     = 7'h05;
   localparam logic [6:0] OP_LDI    = 7'h06;
   localparam logic [6:0] OP_LDUI   = 7'h07;
   localparam logic [6:0] OP_AND    = 7'h08;
   localparam logic [6:0] OP_OR     = 7'h09;
   localparam logic [6:0] OP_XOR    = 7'h0A;
   localparam logic [6:0] OP_NOT    = 7'h0B;
   localparam logic [6:0] OP_ADD    = 7'h0C;
   localparam logic [6:0] OP_SUB    = 7'h0D;
   localparam logic [6:0] OP_FBR    = 7'h0E;
   localparam logic [6:0] OP_FMR    = 7'h0F;
   localparam logic [6:0] OP_QWAIT  = 7'h10;
   localparam logic [6:0] OP_QWAITR = 7'h11;
   localparam logic [6:0] OP_SMSO   = 7'h12;
   localparam logic [6:0] OP_SMSOL  = 7'h13;
   localparam logic [6:0] OP_SITO   = 7'h14;
   localparam logic [6:0] OP_SITOL  = 7'h15;
   localparam logic [6:0] OP_ROT_X  = 7'h18;
   localparam logic [6:0] OP_ROT_Y  = 7'h19;
   localparam logic [6:0] OP_ROT_Z  = 7'h1A;

   localparam logic REGWE_READ  = 1'b0;
   localparam logic REGWE_WRITE = 1'b1;
   localparam logic PC_8        = 1'b0;
   localparam logic PC_JUMP     = 1'b1;

   localparam logic [2:0] IMM_NOP   = 3'd0;
   localparam logic [2:0] IMM_LDI   = 3'd1;
   localparam logic [2:0] IMM_LDUI  = 3'd2;
   localparam logic [2:0] IMM_LDST  = 3'd3;
   localparam logic [2:0] IMM_JUMP  = 3'd4;
   localparam logic [2:0] IMM_BR    = 3'd5;
   localparam logic [2:0] IMM_QWAIT = 3'd6;

   localparam logic [3:0] ALU_ADD = 4'd0;
   localparam logic [3:0] ALU_SUB = 4'd1;
   localparam logic [3:0] ALU_AND = 4'd2;
   localparam logic [3:0] ALU_OR  = 4'd3;
   localparam logic [3:0] ALU_XOR = 4'd4;
   localparam logic [3:0] ALU_NOT = 4'd5;

   localparam logic [2:0] REGSRC_ALU  = 3'd0;
   localparam logic [2:0] REGSRC_MEM  = 3'd1;
   localparam logic [2:0] REGSRC_IMM  = 3'd2;
   localparam logic [2:0] REGSRC_FLAG = 3'd3;
   localparam logic [2:0] REGSRC_MEAS = 3'd4;

   localparam logic [1:0] QRW_NONE  = 2'b00;
   localparam logic [1:0] QRW_ROT   = 2'b01;
   localparam logic [1:0] QRW_SMASK = 2'b10;
   localparam logic [1:0] QRW_TMASK = 2'b11;

   typedef struct packed {
      logic [3:0] alu_op;
      logic       reg_write;
      logic       mem_write;
      logic       branch;
      logic       q_time_write;
      logic       q_time_sel;
      logic       q_vliw;
      logic       q_slm;
      logic       q_rot;
      logic [1:0] q_reg_write;
      logic [2:0] reg_sel;
      logic [2:0] imm_sel;
      logic       time_reg_en;
      logic       sel_mux_b;
      logic       is_payload;
   } ctrl_word_t;

   localparam ctrl_word_t INACTIVE_CTRL = '{
      alu_op:       ALU_ADD,
      reg_write:    REGWE_READ,
      mem_write:    1'b0,
      branch:       PC_8,
      q_time_write: 1'b0,
      q_time_sel:   1'b0,
      q_vliw:       1'b0,
      q_slm:        1'b0,
      q_rot:        1'b0,
      q_reg_write:  QRW_NONE,
      reg_sel:      REGSRC_ALU,
      imm_sel:      IMM_NOP,
      time_reg_en:  1'b0,
      sel_mux_b:    1'b0,
      is_payload:   1'b0
   };

   function automatic logic isVliwLead(input logic [6:0] op);
      return (op == OP_SMSOL) || (op == OP_SITOL);
   endfunction

endpackage

// File: rtl/q_flag_scoreboard.sv
// Pending-flag scoreboard: a CMP marks its flag in flight until execute resolves it.
module q_flag_scoreboard
#(
   parameter int NUM_FLAGS = 16,
   parameter int FLAG_AW   = $clog2(NUM_FLAGS)
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               set_en_i,
   input  logic [FLAG_AW-1:0] set_addr_i,
   input  logic               clr_en_i,
   input  logic [FLAG_AW-1:0] clr_addr_i,
   input  logic [FLAG_AW-1:0] lookup_addr_i,
   output logic               pending_o
);

   logic [NUM_FLAGS-1:0] pending_q, pending_d;

   // Set is applied after clear so a same-index collision leaves the flag pending.
   always_comb begin
      pending_d = pending_q;
      if (clr_en_i) pending_d[clr_addr_i] = 1'b0;
      if (set_en_i) pending_d[set_addr_i] = 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) pending_q <= '0;
      else        pending_q <= pending_d;
   end

   assign pending_o = pending_q[lookup_addr_i];

endmodule

// File: rtl/q_decode_stage.sv
// Registered decode stage with flag scoreboard and VLIW payload counting.
// Optional macro QROT_EN enables decoding of ROT_X/Y/Z as quantum rotations.
module q_decode_stage
   import q_isa_pkg::*;
#(
   parameter int NUM_FLAGS     = 16,
   parameter int FLAG_AW       = $clog2(NUM_FLAGS),
   parameter int PAYLOAD_WORDS = 2
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [6:0]           in_opcode,
   input  logic                 in_q_inst_sign,
   input  logic [FLAG_AW-1:0]   in_flag_addr,
   input  logic [NUM_FLAGS-1:0] comp_flag,
   input  logic                 flag_wr_en,
   input  logic [FLAG_AW-1:0]   flag_wr_addr,
   input  logic                 flush,
   output logic                 out_valid,
   input  logic                 out_ready,
   output ctrl_word_t           out_ctrl,
   output logic                 sign_err
);

   localparam int PCNT_W = $clog2(PAYLOAD_WORDS + 1);

   logic              out_valid_q, out_valid_d;
   ctrl_word_t        out_ctrl_q, out_ctrl_d;
   logic [PCNT_W-1:0] pcnt_q, pcnt_d;
   logic              sign_err_q, sign_err_d;

   logic       in_payload;
   logic       flag_pending;
   logic       stall;
   logic       accept;
   logic       cmp_issue;
   ctrl_word_t dec_ctrl;

   assign in_payload = (pcnt_q != '0);
   assign stall      = in_valid && !in_payload && (in_opcode == OP_BR) && flag_pending;
   assign in_ready   = (!out_valid_q || out_ready) && !stall && !flush;
   assign accept     = in_valid && in_ready;
   assign cmp_issue  = accept && !in_payload && (in_opcode == OP_CMP);

   q_flag_scoreboard #(
      .NUM_FLAGS (NUM_FLAGS),
      .FLAG_AW   (FLAG_AW)
   ) u_scoreboard (
      .clk           (clk),
      .rst_n         (rst_n),
      .set_en_i      (cmp_issue),
      .set_addr_i    (in_flag_addr),
      .clr_en_i      (flag_wr_en),
      .clr_addr_i    (flag_wr_addr),
      .lookup_addr_i (in_flag_addr),
      .pending_o     (flag_pending)
   );

   // Payload words bypass decoding entirely and only carry the payload marker.
   always_comb begin
      dec_ctrl = INACTIVE_CTRL;
      if (in_payload) begin
         dec_ctrl.is_payload = 1'b1;
      end else begin
         case (in_opcode)
            OP_CMP:  dec_ctrl.alu_op = ALU_SUB;
            OP_BR: begin
               dec_ctrl.branch  = comp_flag[in_flag_addr] ? PC_JUMP : PC_8;
               dec_ctrl.imm_sel = IMM_BR;
            end
            OP_JUMP: begin
               dec_ctrl.branch  = PC_JUMP;
               dec_ctrl.imm_sel = IMM_JUMP;
            end
            OP_LD: begin
               dec_ctrl.reg_write = REGWE_WRITE;
               dec_ctrl.imm_sel   = IMM_LDST;
               dec_ctrl.sel_mux_b = 1'b1;
               dec_ctrl.reg_sel   = REGSRC_MEM;
            end
            OP_ST: begin
               dec_ctrl.mem_write = 1'b1;
               dec_ctrl.imm_sel   = IMM_LDST;
               dec_ctrl.sel_mux_b = 1'b1;
            end
            OP_LDI, OP_LDUI: begin
               dec_ctrl.reg_write = REGWE_WRITE;
               dec_ctrl.imm_sel   = (in_opcode == OP_LDI) ? IMM_LDI : IMM_LDUI;
               dec_ctrl.sel_mux_b = 1'b1;
               dec_ctrl.reg_sel   = REGSRC_IMM;
            end
            OP_AND: begin dec_ctrl.reg_write = REGWE_WRITE; dec_ctrl.alu_op = ALU_AND; end
            OP_OR:  begin dec_ctrl.reg_write = REGWE_WRITE; dec_ctrl.alu_op = ALU_OR;  end
            OP_XOR: begin dec_ctrl.reg_write = REGWE_WRITE; dec_ctrl.alu_op = ALU_XOR; end
            OP_NOT: begin dec_ctrl.reg_write = REGWE_WRITE; dec_ctrl.alu_op = ALU_NOT; end
            OP_ADD: begin dec_ctrl.reg_write = REGWE_WRITE; dec_ctrl.alu_op = ALU_ADD; end
            OP_SUB: begin dec_ctrl.reg_write = REGWE_WRITE; dec_ctrl.alu_op = ALU_SUB; end
            OP_FBR: begin dec_ctrl.reg_write = REGWE_WRITE; dec_ctrl.reg_sel = REGSRC_FLAG; end
            OP_FMR: begin dec_ctrl.reg_write = REGWE_WRITE; dec_ctrl.reg_sel = REGSRC_MEAS; end
            OP_QWAIT: begin
               dec_ctrl.q_time_write = 1'b1;
               dec_ctrl.imm_sel      = IMM_QWAIT;
            end
            OP_QWAITR: begin
               dec_ctrl.q_time_write = 1'b1;
               dec_ctrl.q_time_sel   = 1'b1;
               dec_ctrl.time_reg_en  = 1'b1;
            end
            OP_SMSO, OP_SMSOL: begin
               dec_ctrl.q_reg_write = QRW_SMASK;
               dec_ctrl.q_slm       = 1'b1;
               dec_ctrl.q_vliw      = (in_opcode == OP_SMSOL);
            end
            OP_SITO, OP_SITOL: begin
               dec_ctrl.q_reg_write = QRW_TMASK;
               dec_ctrl.q_vliw      = (in_opcode == OP_SITOL);
            end
`ifdef QROT_EN
            OP_ROT_X, OP_ROT_Y, OP_ROT_Z: begin
               dec_ctrl.q_reg_write = QRW_ROT;
               dec_ctrl.q_rot       = 1'b1;
            end
`endif
            default: ;
         endcase
      end
   end

   // Flush and accept never coincide because flush forces in_ready low.
   always_comb begin
      out_valid_d = out_valid_q;
      out_ctrl_d  = out_ctrl_q;
      pcnt_d      = pcnt_q;
      sign_err_d  = 1'b0;
      if (flush) begin
         out_valid_d = 1'b0;
         pcnt_d      = '0;
      end else if (accept) begin
         out_valid_d = 1'b1;
         out_ctrl_d  = dec_ctrl;
         sign_err_d  = (in_q_inst_sign != in_payload);
         if (in_payload)                pcnt_d = pcnt_q - PCNT_W'(1);
         else if (isVliwLead(in_opcode)) pcnt_d = PCNT_W'(PAYLOAD_WORDS);
      end else if (out_ready) begin
         out_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid_q <= 1'b0;
         out_ctrl_q  <= INACTIVE_CTRL;
         pcnt_q      <= '0;
         sign_err_q  <= 1'b0;
      end else begin
         out_valid_q <= out_valid_d;
         out_ctrl_q  <= out_ctrl_d;
         pcnt_q      <= pcnt_d;
         sign_err_q  <= sign_err_d;
      end
   end

   assign out_valid = out_valid_q;
   assign out_ctrl  = out_ctrl_q;
   assign sign_err  = sign_err_q;

endmodule

// File: tb/tb_q_decode_stage.sv
// Scoreboard testbench for q_decode_stage; define QROT_EN to match a rotation-enabled build.
module tb_q_decode_stage;
   import q_isa_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [6:0]  in_opcode;
   logic        in_q_inst_sign;
   logic [3:0]  in_flag_addr;
   logic [15:0] comp_flag;
   logic        flag_wr_en;
   logic [3:0]  flag_wr_addr;
   logic        flush;
   logic        out_valid;
   logic        out_ready;
   ctrl_word_t  out_ctrl;
   logic        sign_err;

   int vectorCount = 0;
   int missCount   = 0;
   ctrl_word_t expQ[$];
   logic       checked = 1'b0;

   q_decode_stage dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .in_valid       (in_valid),
      .in_ready       (in_ready),
      .in_opcode      (in_opcode),
      .in_q_inst_sign (in_q_inst_sign),
      .in_flag_addr   (in_flag_addr),
      .comp_flag      (comp_flag),
      .flag_wr_en     (flag_wr_en),
      .flag_wr_addr   (flag_wr_addr),
      .flush          (flush),
      .out_valid      (out_valid),
      .out_ready      (out_ready),
      .out_ctrl       (out_ctrl),
      .sign_err       (sign_err)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      vectorCount++;
      if (actual !== expected) begin
         missCount++;
         $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, actual, expected, $time);
      end
   endtask

   // Each new output word is compared once against the oldest outstanding expectation.
   always @(negedge clk) begin
      if (rst_n && out_valid) begin
         if (!checked) begin
            if (expQ.size() == 0) checkOutput("unexpected_out", {31'b0, out_valid}, 32'd0);
            else checkOutput("ctrl", {9'b0, out_ctrl}, {9'b0, expQ.pop_front()});
            checked = 1'b1;
         end
         if (out_ready) checked = 1'b0;
      end
   end

   task automatic applyStimulus(input logic [6:0] op, input logic sign, input logic [3:0] flag,
                                input ctrl_word_t expCtrl, input logic expErr);
      int waited = 0;
      in_opcode      = op;
      in_q_inst_sign = sign;
      in_flag_addr   = flag;
      in_valid       = 1'b1;
      @(negedge clk);
      while (!in_ready && waited < 40) begin
         waited++;
         @(negedge clk);
      end
      if (!in_ready) begin
         checkOutput("accept_timeout", {31'b0, in_ready}, 32'd1);
         @(posedge clk); #1;
         in_valid = 1'b0;
      end else begin
         expQ.push_back(expCtrl);
         @(posedge clk); #1;
         in_valid = 1'b0;
         checkOutput("sign_err", {31'b0, sign_err}, {31'b0, expErr});
      end
   endtask

   task automatic resetDut();
      rst_n = 1'b0;
      in_valid = 1'b0; in_opcode = '0; in_q_inst_sign = 1'b0; in_flag_addr = '0;
      comp_flag = '0; flag_wr_en = 1'b0; flag_wr_addr = '0; flush = 1'b0; out_ready = 1'b1;
      expQ.delete();
      checked = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   ctrl_word_t eAdd, eCmp, eBrJ, eBrN, eSmsol, ePay, eAnd, eSt, eSitol, eLdi, eRot, eJump, eQwr, eNone;

   initial begin
      eNone = '0;
      eAdd = '0;   eAdd.reg_write = 1'b1; eAdd.alu_op = 4'd0; eAdd.reg_sel = 3'd0;
      eCmp = '0;   eCmp.alu_op = 4'd1;
      eBrJ = '0;   eBrJ.branch = 1'b1; eBrJ.imm_sel = 3'd5;
      eBrN = '0;   eBrN.imm_sel = 3'd5;
      eJump = '0;  eJump.branch = 1'b1; eJump.imm_sel = 3'd4;
      eSmsol = '0; eSmsol.q_reg_write = 2'b10; eSmsol.q_slm = 1'b1; eSmsol.q_vliw = 1'b1;
      eSitol = '0; eSitol.q_reg_write = 2'b11; eSitol.q_vliw = 1'b1;
      ePay = '0;   ePay.is_payload = 1'b1;
      eAnd = '0;   eAnd.reg_write = 1'b1; eAnd.alu_op = 4'd2;
      eSt = '0;    eSt.mem_write = 1'b1; eSt.imm_sel = 3'd3; eSt.sel_mux_b = 1'b1;
      eLdi = '0;   eLdi.reg_write = 1'b1; eLdi.imm_sel = 3'd1; eLdi.sel_mux_b = 1'b1; eLdi.reg_sel = 3'd2;
      eQwr = '0;   eQwr.q_time_write = 1'b1; eQwr.q_time_sel = 1'b1; eQwr.time_reg_en = 1'b1;
`ifdef QROT_EN
      eRot = '0;   eRot.q_reg_write = 2'b01; eRot.q_rot = 1'b1;
`else
      eRot = '0;
`endif

      resetDut();
      @(negedge clk);
      checkOutput("rst_in_ready", {31'b0, in_ready}, 32'd1);
      checkOutput("rst_out_valid", {31'b0, out_valid}, 32'd0);
      checkOutput("rst_out_ctrl", {9'b0, out_ctrl}, 32'd0);
      checkOutput("rst_sign_err", {31'b0, sign_err}, 32'd0);
      @(posedge clk); #1;

      applyStimulus(OP_ADD, 1'b0, 4'd0, eAdd, 1'b0);
      checkOutput("add_latency", {31'b0, out_valid}, 32'd1);

      // CMP flag 3 then a BR on that flag must wait for the resolve.
      applyStimulus(OP_CMP, 1'b0, 4'd3, eCmp, 1'b0);
      comp_flag[3] = 1'b1;
      in_opcode = OP_BR; in_flag_addr = 4'd3; in_q_inst_sign = 1'b0; in_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         checkOutput("br_stall", {31'b0, in_ready}, 32'd0);
         @(posedge clk); #1;
      end
      flag_wr_en = 1'b1; flag_wr_addr = 4'd3;
      @(negedge clk);
      checkOutput("br_stall_clr_cycle", {31'b0, in_ready}, 32'd0);
      @(posedge clk); #1;
      flag_wr_en = 1'b0;
      applyStimulus(OP_BR, 1'b0, 4'd3, eBrJ, 1'b0);
      applyStimulus(OP_BR, 1'b0, 4'd7, eBrN, 1'b0);
      applyStimulus(OP_JUMP, 1'b0, 4'd0, eJump, 1'b0);

      applyStimulus(OP_SMSOL, 1'b0, 4'd0, eSmsol, 1'b0);
      applyStimulus(7'h16, 1'b1, 4'd0, ePay, 1'b0);
      applyStimulus(7'h16, 1'b1, 4'd0, ePay, 1'b0);
      applyStimulus(OP_ADD, 1'b0, 4'd0, eAdd, 1'b0);
      applyStimulus(OP_AND, 1'b1, 4'd0, eAnd, 1'b1);
      applyStimulus(7'h7F, 1'b0, 4'd0, eNone, 1'b0);
      applyStimulus(OP_QWAITR, 1'b0, 4'd0, eQwr, 1'b0);
      applyStimulus(OP_ROT_Y, 1'b0, 4'd0, eRot, 1'b0);

      // Backpressure: ST held in the output register.
      repeat (2) @(posedge clk);
      #1 out_ready = 1'b0;
      applyStimulus(OP_ST, 1'b0, 4'd0, eSt, 1'b0);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         checkOutput("bp_valid", {31'b0, out_valid}, 32'd1);
         checkOutput("bp_ctrl", {9'b0, out_ctrl}, {9'b0, eSt});
         checkOutput("bp_in_ready", {31'b0, in_ready}, 32'd0);
         @(posedge clk); #1;
      end
      out_ready = 1'b1;

      // Flush in the middle of a SITOL bundle.
      applyStimulus(OP_SITOL, 1'b0, 4'd0, eSitol, 1'b0);
      applyStimulus(7'h16, 1'b1, 4'd0, ePay, 1'b0);
      flush = 1'b1; in_valid = 1'b1; in_opcode = OP_LDI; in_q_inst_sign = 1'b0;
      @(negedge clk);
      checkOutput("flush_in_ready", {31'b0, in_ready}, 32'd0);
      @(posedge clk); #1;
      flush = 1'b0; in_valid = 1'b0;
      checkOutput("flush_out_valid", {31'b0, out_valid}, 32'd0);
      applyStimulus(OP_LDI, 1'b0, 4'd0, eLdi, 1'b0);

      // Same-cycle set and clear of flag 5: the set must win.
      flag_wr_en = 1'b1; flag_wr_addr = 4'd5;
      applyStimulus(OP_CMP, 1'b0, 4'd5, eCmp, 1'b0);
      flag_wr_en = 1'b0;
      comp_flag[5] = 1'b0;
      in_opcode = OP_BR; in_flag_addr = 4'd5; in_valid = 1'b1;
      @(negedge clk);
      checkOutput("collide_stall", {31'b0, in_ready}, 32'd0);
      @(posedge clk); #1;
      flag_wr_en = 1'b1;
      @(posedge clk); #1;
      flag_wr_en = 1'b0;
      applyStimulus(OP_BR, 1'b0, 4'd5, eBrN, 1'b0);

      // Reset mid-payload: nothing of the bundle survives.
      applyStimulus(OP_SMSOL, 1'b0, 4'd0, eSmsol, 1'b0);
      applyStimulus(7'h16, 1'b1, 4'd0, ePay, 1'b0);
      rst_n = 1'b0;
      #1;
      checkOutput("async_rst_valid", {31'b0, out_valid}, 32'd0);
      checkOutput("async_rst_ctrl", {9'b0, out_ctrl}, 32'd0);
      resetDut();
      applyStimulus(OP_ADD, 1'b0, 4'd0, eAdd, 1'b0);

      repeat (3) @(posedge clk);
      #1;
      checkOutput("queue_drained", expQ.size(), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
      $finish;
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
